// File: rtl/mac_dot_seq.sv
// Dot-product sequencer driving one combinational signed MAC: job = (length, bias),
// one operand pair per beat, running sum fed back as preResult. Option: MAC_DOT_SEQ_SAT_EN.
module mac_dot_seq #(
  parameter int LEN   = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   job_len,
  input  logic [LEN-1:0]     job_bias,
  output logic               busy,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [LEN-1:0]     op_a,
  input  logic [LEN-1:0]     op_b,
  output logic [LEN-1:0]     mac_in1,
  output logic [LEN-1:0]     mac_in2,
  output logic [LEN-1:0]     mac_pre,
  input  logic [2*LEN-1:0]   mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [LEN-1:0]     result,
  output logic               ovf,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; ready never depends combinationally on valid, and a producer holds its
  // payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN-1:0]     acc;
  logic [CNT_W-1:0]   remaining;
  logic               ovf_q;
  logic               beat;
  logic               last_beat;
  logic [LEN:0]       top_bits;
  logic               ovf_step;
  logic [LEN-1:0]     narrowed;

  assign beat      = op_valid & op_ready;
  assign last_beat = beat && (remaining == CNT_W'(1));

  // The MAC result fits LEN signed bits only if its sign bit and all higher bits agree.
  assign top_bits = mac_out[2*LEN-1:LEN-1];
  assign ovf_step = ~((&top_bits) | ~(|top_bits));

  always_comb begin
    narrowed = mac_out[LEN-1:0];
`ifdef MAC_DOT_SEQ_SAT_EN
    if (ovf_step) begin
      narrowed = mac_out[2*LEN-1] ? {1'b1, {(LEN-1){1'b0}}} : {1'b0, {(LEN-1){1'b1}}};
    end
`endif
  end

  // MAC is always driven; its output is only committed on a beat.
  assign mac_in1   = op_a;
  assign mac_in2   = op_b;
  assign mac_pre   = acc;
  assign ovf       = ovf_q;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (job_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    result    = '0;
    case (state)
      S_RUN: begin
        busy     = 1'b1;
        op_ready = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        result    = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else if (state == S_IDLE && start) begin
      acc       <= job_bias;
      remaining <= job_len;
      ovf_q     <= 1'b0;
    end else if (beat) begin
      acc       <= narrowed;
      remaining <= remaining - CNT_W'(1);
      ovf_q     <= ovf_q | ovf_step;
    end
  end

endmodule
